// File: rtl/soc_reset_pkg.sv
// Shared types and constants for the SoC reset sequencer.
// State encoding, reset-cause bit positions and the request-vector helper.
`timescale 1ns/1ps
package soc_reset_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STAGGER = 2'd1,
        RUN     = 2'd2
    } rst_state_t;

    localparam int CAUSE_POR    = 0;
    localparam int CAUSE_SYSREQ = 1;
    localparam int CAUSE_WDOG   = 2;
    localparam int CAUSE_LOCKUP = 3;
    localparam int CAUSE_W      = 4;

    localparam logic [CAUSE_W-1:0] POR_CAUSE = CAUSE_W'(1 << CAUSE_POR);

    // One bit per run-time source; the POR bit is never set by a request.
    function automatic logic [CAUSE_W-1:0] req_vector(input logic sysreq,
                                                      input logic wdog,
                                                      input logic lockup);
        logic [CAUSE_W-1:0] v;
        v               = '0;
        v[CAUSE_SYSREQ] = sysreq;
        v[CAUSE_WDOG]   = wdog;
        v[CAUSE_LOCKUP] = lockup;
        return v;
    endfunction

endpackage

// File: rtl/soc_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the
// second clk rising edge after rst falls.
`timescale 1ns/1ps
module soc_reset_sync (
    input  logic clk,
    input  logic rst,
    output logic rst_s
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], 1'b0};
        end
    end

    assign rst_s = sync_reg[1];

endmodule

// File: rtl/soc_reset_ctrl.sv
// Staged reset sequencer: releases the bus domain, then the CPU, and records
// the reset cause. Define SOC_RST_DBG_HOLD_EN to add the CPU_HOLD debug input.
`timescale 1ns/1ps
module soc_reset_ctrl
    import soc_reset_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               SYSRESETREQ,
    input  logic               WDOG_RESET_REQ,
    input  logic               LOCKUP,
    input  logic               LOCKUP_RESET_EN,
`ifdef SOC_RST_DBG_HOLD_EN
    input  logic               CPU_HOLD,
`endif
    output logic               SYS_RESETn,
    output logic               CPU_RESETn,
    output logic [CAUSE_W-1:0] RST_CAUSE,
    output logic               RST_BUSY
);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    logic               rst_s;
    logic               trig;
    logic               cpu_hold;
    logic [CAUSE_W-1:0] req_vec;

    rst_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               sys_reg, sys_next;
    logic               cpu_reg, cpu_next;
    logic [CAUSE_W-1:0] cause_reg, cause_next;
    logic               busy_reg, busy_next;

    soc_reset_sync u_sync (
        .clk   (CLK),
        .rst   (RESET),
        .rst_s (rst_s)
    );

    assign req_vec = req_vector(SYSRESETREQ, WDOG_RESET_REQ, LOCKUP & LOCKUP_RESET_EN);
    assign trig    = |req_vec;

`ifdef SOC_RST_DBG_HOLD_EN
    assign cpu_hold = CPU_HOLD;
`else
    assign cpu_hold = 1'b0;
`endif

    always_ff @(posedge CLK or posedge rst_s) begin
        if (rst_s) begin
            state_reg <= HOLD;
            cnt_reg   <= '0;
            sys_reg   <= 1'b0;
            cpu_reg   <= 1'b0;
            cause_reg <= POR_CAUSE;
            busy_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sys_reg   <= sys_next;
            cpu_reg   <= cpu_next;
            cause_reg <= cause_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sys_next   = sys_reg;
        cpu_next   = cpu_reg;
        cause_next = cause_reg;
        busy_next  = busy_reg;

        case (state_reg)
            HOLD: begin
                if (trig) begin
                    cnt_next   = '0;
                    sys_next   = 1'b0;
                    cause_next = cause_reg | req_vec;
                end else if (cnt_reg == HOLD_LAST) begin
                    cnt_next   = '0;
                    sys_next   = 1'b1;
                    state_next = STAGGER;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STAGGER: begin
                // A request here restarts the whole hold period and re-asserts the bus reset.
                if (trig) begin
                    cnt_next   = '0;
                    sys_next   = 1'b0;
                    cause_next = cause_reg | req_vec;
                    state_next = HOLD;
                end else if (cnt_reg == STAGGER_LAST) begin
                    if (!cpu_hold) begin
                        cnt_next   = '0;
                        cpu_next   = 1'b1;
                        busy_next  = 1'b0;
                        state_next = RUN;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN: begin
                if (trig) begin
                    cnt_next   = '0;
                    sys_next   = 1'b0;
                    cpu_next   = 1'b0;
                    busy_next  = 1'b1;
                    cause_next = req_vec;
                    state_next = HOLD;
                end
            end
            default: begin
                cnt_next   = '0;
                sys_next   = 1'b0;
                cpu_next   = 1'b0;
                busy_next  = 1'b1;
                state_next = HOLD;
            end
        endcase
    end

    assign SYS_RESETn = sys_reg;
    assign CPU_RESETn = cpu_reg;
    assign RST_CAUSE  = cause_reg;
    assign RST_BUSY   = busy_reg;

endmodule

// File: tb/tb_soc_reset_ctrl.sv
// Scoreboard bench for soc_reset_ctrl: stimulus queues expected output
// changes (time + values); a monitor checks every output change against them.
`timescale 1ns/1ps
module tb_soc_reset_ctrl;

    logic       CLK;
    logic       RESET;
    logic       SYSRESETREQ;
    logic       WDOG_RESET_REQ;
    logic       LOCKUP;
    logic       LOCKUP_RESET_EN;
`ifdef SOC_RST_DBG_HOLD_EN
    logic       CPU_HOLD;
`endif
    logic       SYS_RESETn;
    logic       CPU_RESETn;
    logic [3:0] RST_CAUSE;
    logic       RST_BUSY;

    typedef struct {
        time        t;
        logic       sys;
        logic       cpu;
        logic       busy;
        logic [3:0] cause;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ecnt    = 0;
    bit   mon_en  = 0;

    soc_reset_ctrl #(
        .HOLD_CYCLES    (16),
        .STAGGER_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .SYSRESETREQ     (SYSRESETREQ),
        .WDOG_RESET_REQ  (WDOG_RESET_REQ),
        .LOCKUP          (LOCKUP),
        .LOCKUP_RESET_EN (LOCKUP_RESET_EN),
`ifdef SOC_RST_DBG_HOLD_EN
        .CPU_HOLD        (CPU_HOLD),
`endif
        .SYS_RESETn      (SYS_RESETn),
        .CPU_RESETn      (CPU_RESETn),
        .RST_CAUSE       (RST_CAUSE),
        .RST_BUSY        (RST_BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #50 CLK = ~CLK;
    end

    always @(posedge CLK) ecnt <= ecnt + 1;

    // Rising edge n (1-based) occurs at 100*n - 50 ns.
    function automatic time etime(input int n);
        return time'(100 * n - 50);
    endfunction

    task automatic push_at(input time t, input logic sys, input logic cpu,
                           input logic busy, input logic [3:0] cause, input string nm);
        exp_t e;
        e.t = t; e.sys = sys; e.cpu = cpu; e.busy = busy; e.cause = cause; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic push_edge(input int n, input logic sys, input logic cpu,
                             input logic busy, input logic [3:0] cause, input string nm);
        push_at(etime(n), sys, cpu, busy, cause, nm);
    endtask

    task automatic wait_edge(input int n);
        while (ecnt < n) @(negedge CLK);
    endtask

    // {LOCKUP, WDOG, SYSREQ} high for exactly one sampled edge.
    task automatic req_pulse(input logic [2:0] r);
        {LOCKUP, WDOG_RESET_REQ, SYSRESETREQ} = r;
        @(negedge CLK);
        {LOCKUP, WDOG_RESET_REQ, SYSRESETREQ} = 3'b000;
    endtask

    task automatic direct_check(input string nm, input logic sys, input logic cpu,
                                input logic busy, input logic [3:0] cause);
        n_tests++;
        if (SYS_RESETn !== sys || CPU_RESETn !== cpu || RST_BUSY !== busy || RST_CAUSE !== cause) begin
            n_fail++;
            $display("FAIL %s: got sys=%b cpu=%b busy=%b cause=%b, want sys=%b cpu=%b busy=%b cause=%b",
                     nm, SYS_RESETn, CPU_RESETn, RST_BUSY, RST_CAUSE, sys, cpu, busy, cause);
        end else begin
            $display("[TB] ok %s: sys=%b cpu=%b busy=%b cause=%b", nm, sys, cpu, busy, cause);
        end
    endtask

    // Monitor: every output change is one transaction to match against the queue.
    initial begin
        time  t;
        exp_t e;
        wait (mon_en);
        forever begin
            @(SYS_RESETn or CPU_RESETn or RST_BUSY or RST_CAUSE);
            t = $time;
            #1;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change @%0t: sys=%b cpu=%b busy=%b cause=%b, want no change",
                         t, SYS_RESETn, CPU_RESETn, RST_BUSY, RST_CAUSE);
            end else begin
                e = exp_q.pop_front();
                if (t != e.t || SYS_RESETn !== e.sys || CPU_RESETn !== e.cpu ||
                    RST_BUSY !== e.busy || RST_CAUSE !== e.cause) begin
                    n_fail++;
                    $display("FAIL %s: got @%0t sys=%b cpu=%b busy=%b cause=%b, want @%0t sys=%b cpu=%b busy=%b cause=%b",
                             e.nm, t, SYS_RESETn, CPU_RESETn, RST_BUSY, RST_CAUSE,
                             e.t, e.sys, e.cpu, e.busy, e.cause);
                end else begin
                    $display("[TB] ok %s @%0t: sys=%b cpu=%b busy=%b cause=%b",
                             e.nm, t, e.sys, e.cpu, e.busy, e.cause);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit, pending=%0d", exp_q.size());
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int m;
        RESET = 1'b1;
        SYSRESETREQ = 1'b0;
        WDOG_RESET_REQ = 1'b0;
        LOCKUP = 1'b0;
        LOCKUP_RESET_EN = 1'b0;
`ifdef SOC_RST_DBG_HOLD_EN
        CPU_HOLD = 1'b0;
`endif
        #10 mon_en = 1;
        #10 direct_check("reset_state", 1'b0, 1'b0, 1'b1, 4'b0001);

        // Power-on release at 510 ns.
        #490 RESET = 1'b0;
        n = ecnt;
        push_edge(n + 18, 1, 0, 1, 4'b0001, "por_sys_release");
        push_edge(n + 22, 1, 1, 0, 4'b0001, "por_cpu_release");
        wait_edge(n + 25);

        // Single-cycle SYSRESETREQ in RUN.
        n = ecnt;
        push_edge(n + 1,  0, 0, 1, 4'b0010, "sysreq_assert");
        push_edge(n + 17, 1, 0, 1, 4'b0010, "sysreq_sys_release");
        push_edge(n + 21, 1, 1, 0, 4'b0010, "sysreq_cpu_release");
        req_pulse(3'b001);
        wait_edge(n + 24);

        // Simultaneous watchdog and enabled lockup.
        LOCKUP_RESET_EN = 1'b1;
        n = ecnt;
        push_edge(n + 1,  0, 0, 1, 4'b1100, "wdog_lockup_assert");
        push_edge(n + 17, 1, 0, 1, 4'b1100, "wdog_lockup_sys_release");
        push_edge(n + 21, 1, 1, 0, 4'b1100, "wdog_lockup_cpu_release");
        req_pulse(3'b110);
        wait_edge(n + 24);

        // Lockup with the enable cleared must be ignored.
        LOCKUP_RESET_EN = 1'b0;
        LOCKUP = 1'b1;
        repeat (5) @(negedge CLK);
        LOCKUP = 1'b0;
        direct_check("lockup_disabled", 1'b1, 1'b1, 1'b0, 4'b1100);

        // Watchdog during STAGGER restarts the hold and ORs in its cause.
        n = ecnt;
        push_edge(n + 1,  0, 0, 1, 4'b0010, "stagger_first_assert");
        push_edge(n + 17, 1, 0, 1, 4'b0010, "stagger_first_sys_release");
        push_edge(n + 20, 0, 0, 1, 4'b0110, "stagger_wdog_reassert");
        push_edge(n + 36, 1, 0, 1, 4'b0110, "stagger_sys_release");
        push_edge(n + 40, 1, 1, 0, 4'b0110, "stagger_cpu_release");
        req_pulse(3'b001);
        wait_edge(n + 19);
        WDOG_RESET_REQ = 1'b1;
        @(negedge CLK);
        WDOG_RESET_REQ = 1'b0;
        wait_edge(n + 43);

        // RESET asserted mid-STAGGER aborts asynchronously.
        n = ecnt;
        push_edge(n + 1,  0, 0, 1, 4'b0010, "abort_assert");
        push_edge(n + 17, 1, 0, 1, 4'b0010, "abort_sys_release");
        req_pulse(3'b001);
        wait_edge(n + 18);
        push_at($time, 0, 0, 1, 4'b0001, "abort_async_por");
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        m = ecnt;
        push_edge(m + 18, 1, 0, 1, 4'b0001, "abort_por_sys_release");
        push_edge(m + 22, 1, 1, 0, 4'b0001, "abort_por_cpu_release");
        wait_edge(m + 25);

        // Request high on RUN entry re-triggers; held high it keeps HOLD.
        n = ecnt;
        push_edge(n + 1,  0, 0, 1, 4'b0010, "level_first_assert");
        push_edge(n + 17, 1, 0, 1, 4'b0010, "level_first_sys_release");
        push_edge(n + 21, 1, 1, 0, 4'b0010, "level_first_cpu_release");
        push_edge(n + 22, 0, 0, 1, 4'b0100, "level_retrigger");
        push_edge(n + 57, 1, 0, 1, 4'b0100, "level_sys_release");
        push_edge(n + 61, 1, 1, 0, 4'b0100, "level_cpu_release");
        req_pulse(3'b001);
        wait_edge(n + 21);
        WDOG_RESET_REQ = 1'b1;
        wait_edge(n + 41);
        WDOG_RESET_REQ = 1'b0;
        wait_edge(n + 64);

`ifdef SOC_RST_DBG_HOLD_EN
        // Debugger holds the CPU in reset ten extra cycles.
        CPU_HOLD = 1'b1;
        n = ecnt;
        push_edge(n + 1,  0, 0, 1, 4'b0010, "dbg_assert");
        push_edge(n + 17, 1, 0, 1, 4'b0010, "dbg_sys_release");
        push_edge(n + 31, 1, 1, 0, 4'b0010, "dbg_cpu_release");
        req_pulse(3'b001);
        wait_edge(n + 30);
        CPU_HOLD = 1'b0;
        wait_edge(n + 33);
`endif

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d unmatched expected changes, want 0 (next %s)",
                     exp_q.size(), exp_q[0].nm);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_reset_ctrl.md
Name: soc_reset_ctrl

Overview:
Synthesizable reset sequencer for the Cortex-M SoC. It turns the power-on reset and run-time reset requests (CPU SYSRESETREQ, watchdog, lockup) into staged, clock-synchronous reset outputs. The bus/peripheral domain is released first and the CPU a programmable number of cycles later. It also records the cause of the last reset for software.

Parameters:
HOLD_CYCLES, 16, cycles both resets stay asserted after the reset source is removed (min 1)
STAGGER_CYCLES, 4, cycles between SYS_RESETn release and CPU_RESETn release (min 1)
CNT_W, 8, counter width; must hold max(HOLD_CYCLES, STAGGER_CYCLES)

Ports:
CLK  input  1  system clock
RESET  input  1  power-on reset, asynchronous, active-high
SYSRESETREQ  input  1  CPU system reset request, level, CLK-synchronous
WDOG_RESET_REQ  input  1  watchdog reset request, level, CLK-synchronous
LOCKUP  input  1  CPU lockup status, level
LOCKUP_RESET_EN  input  1  1 = LOCKUP triggers a reset
SYS_RESETn  output  1  bus/peripheral reset, active-low, registered
CPU_RESETn  output  1  processor reset, active-low, registered
RST_CAUSE  output  4  cause of last reset, bit-per-source: [0] POR, [1] SYSREQ, [2] WDOG, [3] LOCKUP
RST_BUSY  output  1  1 while the sequence is not in RUN

Behaviour:
- One clock, CLK. RESET is asynchronous and active-high.
- RESET passes through a 2-flop synchroniser: assertion is asynchronous, deassertion is synchronous. Internal rst_s drops on the 2nd CLK rising edge after RESET falls.
- While rst_s=1, all state is forced to: state=HOLD, cnt=0, SYS_RESETn=0, CPU_RESETn=0, RST_CAUSE=4'b0001, RST_BUSY=1.
- trig = SYSRESETREQ | WDOG_RESET_REQ | (LOCKUP & LOCKUP_RESET_EN). The request vector is {LOCKUP&LOCKUP_RESET_EN, WDOG_RESET_REQ, SYSRESETREQ, 0}.
- FSM states: HOLD, STAGGER, RUN.
- HOLD:
  - cnt increments each cycle.
  - When cnt==HOLD_CYCLES-1: cnt<=0, SYS_RESETn<=1, go to STAGGER.
  - Result: SYS_RESETn rises on edge (2+HOLD_CYCLES) after RESET falls.
- STAGGER:
  - cnt increments each cycle.
  - When cnt==STAGGER_CYCLES-1: cnt<=0, CPU_RESETn<=1, RST_BUSY<=0, go to RUN.
- RUN:
  - When trig=1 is sampled: on the next edge SYS_RESETn<=0, CPU_RESETn<=0, RST_BUSY<=1, cnt<=0, RST_CAUSE<=request vector (overwrite, not accumulate), go to HOLD.
  - Simultaneous requests set all corresponding cause bits.
- trig in HOLD or STAGGER:
  - cnt<=0 and SYS_RESETn<=0; state goes to or stays in HOLD.
  - RST_CAUSE ORs in the new request bits. The hold period restarts.
- Requests are level-sensitive. A request still high on entry to RUN re-triggers on the first RUN cycle.
- A RESET assertion at any time aborts the sequence immediately, asynchronously, to the reset values above. POR overrides any recorded cause.
- All outputs come straight from flops; no combinational paths from inputs to outputs.
- Counter compare values are HOLD_CYCLES-1 and STAGGER_CYCLES-1, truncated to CNT_W. cnt never wraps.

Optional Feature:
SOC_RST_DBG_HOLD_EN
- With the macro defined: adds input CPU_HOLD (1 bit).
  - In STAGGER at count end, if CPU_HOLD=1: stay in STAGGER with cnt saturated and CPU_RESETn=0, until CPU_HOLD=0.
  - CPU_RESETn<=1 on the edge where CPU_HOLD=0 is sampled.
  - SYS_RESETn is unaffected, so the debugger can access the bus while the CPU is held.
- Without the macro: no port; behaviour exactly as above.

Decomposition:
- Package soc_reset_pkg holds:
  - state encoding: HOLD=2'd0, STAGGER=2'd1, RUN=2'd2
  - cause bit indices: CAUSE_POR=0, CAUSE_SYSREQ=1, CAUSE_WDOG=2, CAUSE_LOCKUP=3
  - RST_CAUSE width constant = 4
- One sub-module is natural: soc_reset_sync, the 2-flop async-assert/sync-deassert synchroniser. It is reusable for other reset domains.

Test Plan:
All tests use a 100 ns clock period.
- POR: RESET=1 for 510 ns then 0, HOLD_CYCLES=16, STAGGER_CYCLES=4 -> SYS_RESETn rises on edge 18 after RESET falls; CPU_RESETn rises on edge 22; RST_CAUSE=0001; RST_BUSY falls with CPU_RESETn.
- SYSRESETREQ: pulse 1 cycle in RUN -> both resets low on the next edge; SYS_RESETn high 16 edges later; CPU_RESETn high 4 edges after that; RST_CAUSE=0010.
- Simultaneous WDOG+LOCKUP with LOCKUP_RESET_EN=1 -> RST_CAUSE=1100. Repeat with LOCKUP_RESET_EN=0 and LOCKUP only -> no reset; outputs stay 1.
- WDOG_RESET_REQ during STAGGER (2 cycles after SYS_RESETn rise) -> SYS_RESETn low next edge; hold restarts with a full 16 cycles; RST_CAUSE ORs in bit 2.
- RESET asserted mid-STAGGER -> SYS_RESETn=0, CPU_RESETn=0, RST_CAUSE=0001 within the same timestep (asynchronous); check the sequence restarts cleanly. Also: request held high continuously -> reset re-enters HOLD on the first RUN cycle.
- SOC_RST_DBG_HOLD_EN build: CPU_HOLD=1 through the STAGGER end -> CPU_RESETn stays 0 for 10 extra cycles while SYS_RESETn=1; drop CPU_HOLD -> CPU_RESETn=1 on the next edge.
